// File: rtl/box_field_ctrl.sv
// box_field_ctrl: falling-box playfield, hit/miss judging and scoring
// for the LED matrix scanner. Row codes: 0..3 = box in lane, 4 = empty.
module box_field_ctrl #(
    parameter int unsigned STEP_DIV   = 3000000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5,
    parameter int unsigned MISS_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  btn,
    output logic [14:0] rows_flat,
    output logic [7:0]  score,
    output logic [3:0]  miss,
    output logic [1:0]  state,
    output logic        game_over,
    output logic        step
);

    localparam int unsigned PW         = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV + 1);
    localparam logic [PW-1:0] PS_TC    = PW'(STEP_DIV);
    localparam logic [7:0]  SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [3:0]  MISS_LIM   = 4'(MISS_LIMIT);
    localparam logic [2:0]  EMPTY      = 3'd4;
    localparam logic [14:0] EMPTY_ROWS = {5{3'd4}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        sync1;
    logic [3:0]        sync2;
    logic [3:0]        sync3;
    logic [3:0]        press;
    logic              any_press;
    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic [7:0]        lfsr_q;
    logic [7:0]        lfsr_d;
    logic [4:0][2:0]   rows_q;
    logic [4:0][2:0]   rows_d;
    logic [7:0]        score_q;
    logic [7:0]        score_d;
    logic [3:0]        miss_q;
    logic [3:0]        miss_d;
    logic              step_q;
    logic              step_d;
    logic              over_q;
    logic              over_d;
    logic              tick;
    logic              hit;
    logic [2:0]        new_code;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign press     = sync2 & ~sync3;
    assign any_press = |press;
    // step_q is high exactly while the prescaler sits at its terminal count in PLAY
    assign tick      = step_q;
    assign new_code  = lfsr_q[2] ? EMPTY : {1'b0, lfsr_q[1:0]};
    assign hit       = (rows_q[4] != EMPTY) && press[rows_q[4][1:0]];

    // FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_press) state_d = S_PLAY;
            S_PLAY:  if (miss_q >= MISS_LIM) state_d = S_OVER;
            S_OVER:  if (any_press) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Playfield, scoring, prescaler and LFSR next values
    always_comb begin
        rows_d  = rows_q;
        score_d = score_q;
        miss_d  = miss_q;
        presc_d = presc_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            S_IDLE: begin
                rows_d = EMPTY_ROWS;
                if (state_d == S_PLAY) begin
                    score_d = '0;
                    miss_d  = '0;
                    presc_d = '0;
                end
            end
            S_PLAY: begin
                if (state_d == S_OVER) begin
                    rows_d = EMPTY_ROWS;
                end else begin
                    presc_d = (presc_q == PS_TC) ? '0 : presc_q + PW'(1);
                    if (hit) begin
                        score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        rows_d[4] = EMPTY;
                    end
                    // Hit is judged against the pre-shift bottom row, so the shift overrides it
                    if (tick) begin
                        if ((rows_q[4] != EMPTY) && !hit) begin
                            miss_d = (miss_q >= MISS_LIM) ? miss_q : miss_q + 4'd1;
                        end
                        rows_d = {rows_q[3:0], new_code};
                        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    end
                end
            end
            S_OVER: begin
                rows_d = EMPTY_ROWS;
            end
            default: begin
                rows_d = EMPTY_ROWS;
            end
        endcase
        step_d = (state_d == S_PLAY) && (presc_d == PS_TC);
        over_d = (state_d == S_OVER);
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rows_q  <= EMPTY_ROWS;
            score_q <= '0;
            miss_q  <= '0;
            presc_q <= '0;
            lfsr_q  <= SEED;
            step_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            rows_q  <= rows_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            presc_q <= presc_d;
            lfsr_q  <= lfsr_d;
            step_q  <= step_d;
            over_q  <= over_d;
        end
    end

    assign rows_flat = rows_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign state     = state_q;
    assign game_over = over_q;
    assign step      = step_q;

endmodule

// File: tb/tb_box_field_ctrl.sv
// Directed testbench for box_field_ctrl: two instances with different
// parameters, one for scroll/hit/reset scenarios, one for miss/saturation.
module tb_box_field_ctrl;

    logic        CLK = 1'b0;
    logic        rstn_a, rstn_b;
    logic [3:0]  btn_a, btn_b;
    logic [14:0] rows_a, rows_b;
    logic [7:0]  score_a, score_b;
    logic [3:0]  miss_a, miss_b;
    logic [1:0]  state_a, state_b;
    logic        go_a, go_b;
    logic        step_a, step_b;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    box_field_ctrl #(.STEP_DIV(3), .LFSR_SEED(8'h01), .MISS_LIMIT(8)) u_a (
        .CLK(CLK), .RSTn(rstn_a), .btn(btn_a), .rows_flat(rows_a), .score(score_a),
        .miss(miss_a), .state(state_a), .game_over(go_a), .step(step_a)
    );

    box_field_ctrl #(.STEP_DIV(11), .LFSR_SEED(8'hA5), .MISS_LIMIT(2)) u_b (
        .CLK(CLK), .RSTn(rstn_b), .btn(btn_b), .rows_flat(rows_b), .score(score_b),
        .miss(miss_b), .state(state_b), .game_over(go_b), .step(step_b)
    );

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Returns at the first negedge (including the current one) where step is high
    task automatic wait_step(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((sel ? step_b : step_a) == 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic pulse_a(input logic [3:0] v);
        btn_a = v;
        nclk(1);
        btn_a = '0;
    endtask

    task automatic pulse_b(input logic [3:0] v);
        btn_b = v;
        nclk(1);
        btn_b = '0;
    endtask

    task automatic test_reset();
        int n;
        rstn_a = 1'b0; rstn_b = 1'b0; btn_a = '0; btn_b = '0;
        nclk(2);
        tests++; if (rows_a !== 15'h4924) begin fails++; $display("FAIL reset_rows_a: got %h exp %h", rows_a, 15'h4924); end
        tests++; if (rows_b !== 15'h4924) begin fails++; $display("FAIL reset_rows_b: got %h exp %h", rows_b, 15'h4924); end
        tests++; if ({score_a, miss_a, state_a, go_a, step_a} !== 16'h0) begin fails++; $display("FAIL reset_outs_a: got %h exp 0", {score_a, miss_a, state_a, go_a, step_a}); end
        rstn_a = 1'b1; rstn_b = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (step_a || step_b) n++;
        end
        tests++; if (n != 0) begin fails++; $display("FAIL idle_no_step: got %0d pulses exp 0", n); end
        tests++; if (state_a !== 2'd0) begin fails++; $display("FAIL idle_state: got %0d exp 0", state_a); end
    endtask

    task automatic test_scroll();
        logic [2:0]  exp_r0 [0:4];
        int unsigned last;
        bit          ok;
        exp_r0 = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd1};
        last = 0;
        pulse_a(4'b0001);
        for (int t = 0; t < 5; t++) begin
            wait_step(1'b0, ok);
            tests++; if (!ok) begin fails++; $display("FAIL scroll_tick%0d: got timeout exp step", t + 1); end
            if (t > 0) begin
                tests++; if (cyc - last != 4) begin fails++; $display("FAIL step_period: got %0d exp 4", cyc - last); end
            end
            last = cyc;
            nclk(1);
            tests++; if (rows_a[2:0] !== exp_r0[t]) begin fails++; $display("FAIL scroll_row0_t%0d: got %0d exp %0d", t + 1, rows_a[2:0], exp_r0[t]); end
        end
        tests++; if (rows_a !== 15'h1501) begin fails++; $display("FAIL scroll_rows: got %h exp %h", rows_a, 15'h1501); end
        tests++; if (state_a !== 2'd1) begin fails++; $display("FAIL scroll_state: got %0d exp 1", state_a); end
    endtask

    // Entered one negedge after tick 5
    task automatic test_hit();
        pulse_a(4'b0010);
        nclk(1);
        tests++; if (score_a !== 8'd0) begin fails++; $display("FAIL hit_latency: got %0d exp 0", score_a); end
        nclk(1);
        tests++; if (score_a !== 8'd1) begin fails++; $display("FAIL hit_score: got %0d exp 1", score_a); end
        tests++; if (rows_a !== 15'h4501) begin fails++; $display("FAIL hit_rows: got %h exp %h", rows_a, 15'h4501); end
        tests++; if (step_a !== 1'b1) begin fails++; $display("FAIL hit_step6: got %0d exp 1", step_a); end
        nclk(1);
        tests++; if (rows_a !== 15'h280B) begin fails++; $display("FAIL tick6_rows: got %h exp %h", rows_a, 15'h280B); end
        tests++; if (miss_a !== 4'd0) begin fails++; $display("FAIL tick6_miss: got %0d exp 0", miss_a); end
        // Wrong lane: no score change, row4 keeps its box, then it misses at tick 7
        pulse_a(4'b1000);
        nclk(2);
        tests++; if (score_a !== 8'd1) begin fails++; $display("FAIL nomatch_score: got %0d exp 1", score_a); end
        tests++; if (rows_a !== 15'h280B) begin fails++; $display("FAIL nomatch_rows: got %h exp %h", rows_a, 15'h280B); end
        nclk(1);
        tests++; if (miss_a !== 4'd1) begin fails++; $display("FAIL tick7_miss: got %0d exp 1", miss_a); end
        tests++; if (rows_a !== 15'h405C) begin fails++; $display("FAIL tick7_rows: got %h exp %h", rows_a, 15'h405C); end
    endtask

    // Press on lane 0 judged on the same edge as tick 9
    task automatic test_simultaneous();
        bit ok;
        wait_step(1'b0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL sim_tick8: got timeout exp step"); end
        nclk(1);
        tests++; if (rows_a !== 15'h02E4) begin fails++; $display("FAIL tick8_rows: got %h exp %h", rows_a, 15'h02E4); end
        nclk(1);
        pulse_a(4'b0001);
        nclk(1);
        tests++; if (step_a !== 1'b1) begin fails++; $display("FAIL sim_align: got %0d exp 1", step_a); end
        nclk(1);
        tests++; if (score_a !== 8'd2) begin fails++; $display("FAIL sim_score: got %0d exp 2", score_a); end
        tests++; if (miss_a !== 4'd1) begin fails++; $display("FAIL sim_miss: got %0d exp 1", miss_a); end
        tests++; if (rows_a !== 15'h1724) begin fails++; $display("FAIL sim_rows: got %h exp %h", rows_a, 15'h1724); end
    endtask

    task automatic test_reset_mid_play();
        int         hits;
        int         n;
        bit         ok;
        logic [3:0] v;
        hits = 0;
        for (int i = 0; i < 60 && hits < 3; i++) begin
            if (rows_a[14:12] != 3'd4) begin
                v = 4'b0001 << rows_a[13:12];
                pulse_a(v);
                hits++;
                nclk(2);
            end
            if (hits < 3) begin
                wait_step(1'b0, ok);
                if (!ok) break;
                nclk(1);
            end
        end
        tests++; if (score_a !== 8'd5) begin fails++; $display("FAIL pre_reset_score: got %0d exp 5", score_a); end
        tests++; if (miss_a !== 4'd1) begin fails++; $display("FAIL pre_reset_miss: got %0d exp 1", miss_a); end
        rstn_a = 1'b0;
        #1;
        tests++; if (rows_a !== 15'h4924) begin fails++; $display("FAIL midreset_rows: got %h exp %h", rows_a, 15'h4924); end
        tests++; if (score_a !== 8'd0) begin fails++; $display("FAIL midreset_score: got %0d exp 0", score_a); end
        tests++; if (state_a !== 2'd0) begin fails++; $display("FAIL midreset_state: got %0d exp 0", state_a); end
        nclk(2);
        rstn_a = 1'b1;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            if (step_a) n++;
        end
        tests++; if (n != 0) begin fails++; $display("FAIL midreset_idle_steps: got %0d exp 0", n); end
    endtask

    task automatic test_miss_game_over();
        logic [3:0] exp_miss [0:8];
        logic [2:0] exp_r0 [0:8];
        int         n;
        bit         ok;
        exp_miss = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};
        exp_r0   = '{3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd1, 3'd3, 3'd4, 3'd4};
        pulse_b(4'b0100);
        for (int t = 0; t < 9; t++) begin
            wait_step(1'b1, ok);
            tests++; if (!ok) begin fails++; $display("FAIL miss_tick%0d: got timeout exp step", t + 1); end
            nclk(1);
            tests++; if (miss_b !== exp_miss[t]) begin fails++; $display("FAIL miss_t%0d: got %0d exp %0d", t + 1, miss_b, exp_miss[t]); end
            tests++; if (rows_b[2:0] !== exp_r0[t]) begin fails++; $display("FAIL b_row0_t%0d: got %0d exp %0d", t + 1, rows_b[2:0], exp_r0[t]); end
        end
        tests++; if (state_b !== 2'd1) begin fails++; $display("FAIL limit_state_pre: got %0d exp 1", state_b); end
        nclk(1);
        tests++; if (state_b !== 2'd2) begin fails++; $display("FAIL over_state: got %0d exp 2", state_b); end
        tests++; if (go_b !== 1'b1) begin fails++; $display("FAIL over_flag: got %0d exp 1", go_b); end
        tests++; if (rows_b !== 15'h4924) begin fails++; $display("FAIL over_rows: got %h exp %h", rows_b, 15'h4924); end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (step_b) n++;
        end
        tests++; if (n != 0) begin fails++; $display("FAIL over_steps: got %0d exp 0", n); end
        tests++; if ({score_b, miss_b} !== {8'd0, 4'd2}) begin fails++; $display("FAIL over_frozen: got %h exp %h", {score_b, miss_b}, {8'd0, 4'd2}); end
        pulse_b(4'b0010);
        nclk(2);
        tests++; if (state_b !== 2'd0) begin fails++; $display("FAIL over_to_idle: got %0d exp 0", state_b); end
        tests++; if (go_b !== 1'b0) begin fails++; $display("FAIL idle_flag: got %0d exp 0", go_b); end
    endtask

    task automatic test_saturation();
        int         hits;
        bit         ok;
        logic [3:0] v;
        pulse_b(4'b0001);
        nclk(2);
        tests++; if (state_b !== 2'd1) begin fails++; $display("FAIL sat_start: got %0d exp 1", state_b); end
        tests++; if (miss_b !== 4'd0) begin fails++; $display("FAIL sat_miss_clear: got %0d exp 0", miss_b); end
        hits = 0;
        for (int i = 0; i < 1500 && hits < 260; i++) begin
            wait_step(1'b1, ok);
            if (!ok) begin
                tests++; fails++;
                $display("FAIL sat_tick: got timeout exp step");
                break;
            end
            nclk(1);
            if (rows_b[14:12] != 3'd4) begin
                v = 4'b0001 << rows_b[13:12];
                pulse_b(v);
                hits++;
                nclk(2);
                if (hits == 255) begin
                    tests++; if (score_b !== 8'd255) begin fails++; $display("FAIL sat_255: got %0d exp 255", score_b); end
                end
            end
        end
        tests++; if (hits != 260) begin fails++; $display("FAIL sat_hits: got %0d exp 260", hits); end
        tests++; if (score_b !== 8'd255) begin fails++; $display("FAIL sat_score: got %0d exp 255", score_b); end
        tests++; if (miss_b !== 4'd0) begin fails++; $display("FAIL sat_miss: got %0d exp 0", miss_b); end
        tests++; if (state_b !== 2'd1) begin fails++; $display("FAIL sat_state: got %0d exp 1", state_b); end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_hit();
        test_simultaneous();
        test_reset_mid_play();
        test_miss_game_over();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/box_field_ctrl.md
Name: box_field_ctrl

Overview:
- Game-state stage that sits directly upstream of the LED matrix scanner.
- Keeps the 5-row falling-box playfield: each row holds a lane code, 0..3 = box in that lane, 4 = empty.
- Scrolls the playfield down one row per step tick and injects new pseudo-random rows at the top.
- Judges player button presses against the bottom (hit) row and keeps score and miss counts.
- Exports the row codes in the same encoding the scanner consumes.

Parameters:
- STEP_DIV, 3000000: step prescaler terminal count; step period = STEP_DIV+1 clocks.
- LFSR_SEED, 8'hA5: LFSR value loaded at reset; a value of 0 is replaced by 8'h01.
- MISS_LIMIT, 8: miss count that ends the game; valid range 1..15.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  asynchronous active-low reset
- btn  in  4  raw lane buttons, active-high, asynchronous to CLK
- rows_flat  out  15  row codes; [2:0]=row0 (top/newest) .. [14:12]=row4 (bottom/hit row)
- score  out  8  hits, saturating at 255
- miss  out  4  misses, saturating at MISS_LIMIT
- state  out  2  0=IDLE, 1=PLAY, 2=OVER
- game_over  out  1  high while state==OVER
- step  out  1  one-cycle pulse on each step tick in PLAY

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous and active-low on RSTn.
- Reset values:
  - all rows = 4
  - score = 0, miss = 0
  - state = IDLE, game_over = 0, step = 0
  - prescaler = 0
  - lfsr = LFSR_SEED (or 8'h01 if the seed is 0)
  - synchronizer flops = 0
- Input conditioning:
  - Each btn bit passes through a 2-flop synchronizer, then a rising-edge detect producing press[i] (one cycle).
  - Latency from btn edge to press is 3 clocks.
- Prescaler:
  - Runs only in PLAY; counts 0..STEP_DIV, then wraps to 0.
  - tick = (prescaler==STEP_DIV), exported as step.
  - Cleared to 0 on the IDLE->PLAY transition.
- LFSR:
  - 8-bit Fibonacci. On each tick: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Holds when there is no tick.
  - The new row uses the pre-advance value: code = lfsr[2] ? 4 : lfsr[1:0].
- FSM:
  - IDLE: rows held empty. Any press -> PLAY; on that edge clear score, miss and prescaler. The LFSR is not reseeded.
  - PLAY:
    - Hit: a press on lane L with row4==L (L!=4) gives score+1 (saturating) and row4 <= 4. Multiple simultaneous presses count at most one hit per cycle. Presses on a non-matching lane or an empty row4 have no effect.
    - On tick: if row4!=4 and it was not hit this cycle, miss+1. Then row[k] <= row[k-1] for k=4..1, and row0 <= new code.
    - Same cycle press + tick: the hit is judged against the pre-shift row4. A hit suppresses the miss, and row4 then takes row3.
    - When miss reaches MISS_LIMIT -> OVER on the next clock. Rows are cleared to 4.
  - OVER: rows empty; score and miss frozen; ticks stop. Any press -> IDLE.
- Outputs are registered; there are no combinational paths from btn to outputs.

Test Plan:
- Reset then idle: assert RSTn=0 mid-PLAY with score=5 -> rows_flat=15'h4924 and score=0 immediately; state=IDLE; no step pulses while idle.
- Scroll sequence:
  - Setup: STEP_DIV=3, LFSR_SEED=8'h01, press btn[0] to start.
  - Expected: step pulses every 4 clocks. New row0 codes are 1, 2, 4, 0, 1 on ticks 1..5 (lfsr 01, 02, 04, 08, 11).
  - After tick 5: row4=1, row3=2, row2=4, row1=0, row0=1.
- Hit: in the same setup after tick 5, pulse btn[1] -> 3 clocks later score=1 and row4=4. Pulsing btn[3] instead leaves score=0.
- Miss and game over:
  - Setup: MISS_LIMIT=2, no presses.
  - Expected: miss increments at each tick where row4!=4. At miss=2, state=OVER and game_over=1; rows go empty and score is frozen.
  - Any press then returns state to IDLE.
- Simultaneous press and tick: align a btn[L] press with a tick while row4==L -> score+1, miss unchanged, row4 = old row3.
- Saturation: force 256 hits -> score stays 255.
